// File: rtl/rv32i_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// rv32i_mem_arbiter_if
//   Bundles the two core-side requesters (instruction fetch I, load/store D)
//   and the single memory port into one interface.
//
//   slave  : arbiter view (takes requests, drives acks and the memory port)
//   master : core/memory view (drives requests and memory responses)
//
//   I side : i_req, i_addr -> i_ack, i_err, i_rdata
//   D side : d_req, d_we, d_addr, d_wdata -> d_ack, d_err, d_rdata
//   Memory : mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata, mem_ack
// ----------------------------------------------------------------------------
interface rv32i_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch requester
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic              i_err;
    logic [DATA_W-1:0] i_rdata;

    // load/store requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic              d_err;
    logic [DATA_W-1:0] d_rdata;

    // shared memory port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  i_req, i_addr,
        output i_ack, i_err, i_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_ack, d_err, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport master (
        output i_req, i_addr,
        input  i_ack, i_err, i_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_ack, d_err, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// ----------------------------------------------------------------------------
// rv32i_mem_arbiter
//   Shares one single-port RAM between the RV32I fetch requester (I) and the
//   load/store requester (D). D wins ties unless I has been passed over
//   STARVE_MAX times in a row; each transaction aborts with an error ack if
//   the memory does not answer within TIMEOUT busy cycles.
//
//   Ports
//     clk   : rising-edge clock
//     reset : asynchronous, active-high
//     bus   : rv32i_mem_arbiter_if.slave (requesters + memory port)
//
//   All outputs come straight from flops.
// ----------------------------------------------------------------------------
module rv32i_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                clk,
    input  logic                reset,
    rv32i_mem_arbiter_if.slave  bus
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic [SW-1:0]     starve_q,    starve_d;
    logic [TW-1:0]     tmo_q,       tmo_d;

    logic              i_ack_q,     i_ack_d;
    logic              i_err_q,     i_err_d;
    logic [DATA_W-1:0] i_rdata_q,   i_rdata_d;
    logic              d_ack_q,     d_ack_d;
    logic              d_err_q,     d_err_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;

    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    // A requester whose ack is still high has just completed; masking it
    // for that cycle forces a one-cycle gap and lets the other side in.
    logic i_elig, d_elig;
    assign i_elig = bus.i_req && !i_ack_q;
    assign d_elig = bus.d_req && !d_ack_q;

    // ------------------------------------------------------------------
    // state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            tmo_q       <= '0;
            i_ack_q     <= 1'b0;
            i_err_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            i_ack_q     <= i_ack_d;
            i_err_q     <= i_err_d;
            i_rdata_q   <= i_rdata_d;
            d_ack_q     <= d_ack_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // ------------------------------------------------------------------
    // next state / outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        i_ack_d     = 1'b0;
        i_err_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_ack_d     = 1'b0;
        d_err_d     = 1'b0;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (d_elig && !(i_elig && starve_q == STARVE_LIM)) begin
                    state_d     = BUSY_D;
                    tmo_d       = '0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_we ? bus.d_wdata : '0;
                    // only a D grant that actually bypassed a waiting I counts
                    if (!i_elig)
                        starve_d = '0;
                    else if (starve_q != STARVE_LIM)
                        starve_d = starve_q + SW'(1);
                end else if (i_elig) begin
                    state_d     = BUSY_I;
                    tmo_d       = '0;
                    starve_d    = '0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.i_addr;
                    mem_wdata_d = '0;
                end
            end

            BUSY_I, BUSY_D: begin
                // mem_ack takes precedence over the timeout on the same edge
                if (bus.mem_ack || tmo_q == TMO_LAST) begin
                    state_d     = IDLE;
                    tmo_d       = '0;
                    mem_en_d    = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    if (state_q == BUSY_I) begin
                        i_ack_d   = 1'b1;
                        i_err_d   = !bus.mem_ack;
                        i_rdata_d = bus.mem_ack ? bus.mem_rdata : '0;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_err_d   = !bus.mem_ack;
                        d_rdata_d = (bus.mem_ack && !mem_we_q) ? bus.mem_rdata : '0;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            default: begin
                state_d     = IDLE;
                mem_en_d    = 1'b0;
                mem_we_d    = 1'b0;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
            end
        endcase
    end

    assign bus.i_ack     = i_ack_q;
    assign bus.i_err     = i_err_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_err     = d_err_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule
